frl_rx_tap_train_ctrl: RTL and testbench

Receive-side training controller for the Fast Radio Link. It sits directly upstream of the 7-bit up/down tap counter and drives that counter's count/ud command pair.
- Sweeps the tap from 0 upward, checking deserialized words against the known training pattern at each tap.
- Finds the first passing eye of sufficient width and steps back to its centre.
- Reports lock, then counts bit errors while locked.

---
 rtl/frl_rx_tap_train_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_frl_rx_tap_train_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frl_rx_tap_train_ctrl.sv
// rtl/frl_rx_tap_train_ctrl.sv - receive tap sweep, eye centring and lock error counting
module frl_rx_tap_train_ctrl #(
    parameter logic [7:0] PATTERN    = 8'h5C,
    parameter int         WINDOW     = 64,
    parameter int         SETTLE_CYC = 16,
    parameter int         MIN_EYE    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        retrain,
    output logic        count,
    output logic        ud,
    output logic [6:0]  tap_pos,
    output logic        locked,
    output logic        fail,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {
        S_CLEAR, S_SETTLE, S_MEASURE, S_EVAL, S_STEP, S_CENTER, S_LOCKED, S_FAIL
    } state_e;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_HOLD  = 2'b01;
    localparam logic [1:0] CMD_DEC   = 2'b10;
    localparam logic [1:0] CMD_INC   = 2'b11;

    state_e      state_q, state_d;
    logic [6:0]  tap_q, tap_d;
    logic [7:0]  settle_q, settle_d;
    logic [8:0]  win_q, win_d;
    logic        mism_q, mism_d;
    logic        in_eye_q, in_eye_d;
    logic [6:0]  eye_start_q, eye_start_d;
    logic [6:0]  eye_end_q, eye_end_d;
    logic [15:0] err_q, err_d;
    logic        locked_q, locked_d;
    logic        fail_q, fail_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [7:0]  width_w;
    logic        go_center_w;

    // Centre of the eye, rounded toward eye_start so it never undershoots the eye.
    function automatic logic [6:0] center_tgt(input logic [6:0] s, input logic [6:0] e);
        return s + ((e - s) >> 1);
    endfunction

    // State and all registered outputs; reset keeps the counter driven to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            tap_q       <= '0;
            settle_q    <= '0;
            win_q       <= '0;
            mism_q      <= 1'b0;
            in_eye_q    <= 1'b0;
            eye_start_q <= '0;
            eye_end_q   <= '0;
            err_q       <= '0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            cmd_q       <= CMD_CLEAR;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            settle_q    <= settle_d;
            win_q       <= win_d;
            mism_q      <= mism_d;
            in_eye_q    <= in_eye_d;
            eye_start_q <= eye_start_d;
            eye_end_q   <= eye_end_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            cmd_q       <= cmd_d;
        end
    end

    // Next state, eye tracking, and the command that will be presented in the next state.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        settle_d    = '0;
        win_d       = '0;
        mism_d      = mism_q;
        in_eye_d    = in_eye_q;
        eye_start_d = eye_start_q;
        eye_end_d   = eye_end_q;
        err_d       = err_q;
        width_w     = '0;
        go_center_w = 1'b0;

        case (state_q)
            S_CLEAR: begin
                in_eye_d = 1'b0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                mism_d = 1'b0;
                if (settle_q == 8'(SETTLE_CYC - 1)) begin
                    state_d = S_MEASURE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_MEASURE: begin
                win_d = win_q;
                if (din_valid) begin
                    win_d = win_q + 9'd1;
                    if (din != PATTERN) begin
                        mism_d = 1'b1;
                    end
                    if (win_q == 9'(WINDOW - 1)) begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                if (!mism_q) begin
                    if (!in_eye_q) begin
                        eye_start_d = tap_q;
                        in_eye_d    = 1'b1;
                    end
                    eye_end_d = tap_q;
                end
                width_w = {1'b0, eye_end_d} - {1'b0, eye_start_d} + 8'd1;
                if (mism_q && in_eye_q) begin
                    if (width_w >= 8'(MIN_EYE)) begin
                        go_center_w = 1'b1;
                    end else begin
                        in_eye_d = 1'b0;
                    end
                end
                if (go_center_w) begin
                    state_d = S_CENTER;
                end else if (tap_q == 7'd127) begin
                    state_d = (in_eye_d && width_w >= 8'(MIN_EYE)) ? S_CENTER : S_FAIL;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                tap_d   = tap_q + 7'd1;
                state_d = S_SETTLE;
            end
            S_CENTER: begin
                if (tap_q != center_tgt(eye_start_q, eye_end_q)) begin
                    tap_d = tap_q - 7'd1;
                end else begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (din_valid && din != PATTERN && err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end
            end
            S_FAIL: begin
            end
            default: state_d = S_CLEAR;
        endcase

        if (retrain) begin
            state_d     = S_CLEAR;
            in_eye_d    = 1'b0;
            eye_start_d = '0;
            eye_end_d   = '0;
            err_d       = '0;
        end
        if (state_d == S_CLEAR) begin
            tap_d = '0;
        end

        locked_d = (state_d == S_LOCKED);
        fail_d   = (state_d == S_FAIL);

        case (state_d)
            S_CLEAR:  cmd_d = CMD_CLEAR;
            S_STEP:   cmd_d = CMD_INC;
            S_CENTER: cmd_d = (tap_d != center_tgt(eye_start_d, eye_end_d)) ? CMD_DEC : CMD_HOLD;
            default:  cmd_d = CMD_HOLD;
        endcase
    end

    assign count   = cmd_q[1];
    assign ud      = cmd_q[0];
    assign tap_pos = tap_q;
    assign locked  = locked_q;
    assign fail    = fail_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_frl_rx_tap_train_ctrl.sv
// tb/tb_frl_rx_tap_train_ctrl.sv - scoreboard bench for frl_rx_tap_train_ctrl
module tb_frl_rx_tap_train_ctrl;

    localparam logic [7:0] PAT  = 8'h5C;
    localparam int         WIN  = 8;
    localparam int         SET  = 16;
    localparam int         MINE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        retrain;
    logic        count;
    logic        ud;
    logic [6:0]  tap_pos;
    logic        locked;
    logic        fail;
    logic [15:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    int lo1, hi1, lo2, hi2;
    bit corrupt = 1'b0;
    bit half    = 1'b0;
    bit tog     = 1'b0;

    logic [6:0] m_tap;
    int         inc_n, dec_n;

    typedef struct {
        int inc;
        int dec;
        int tap;
        bit lk;
        bit fl;
    } exp_t;
    exp_t exp_q[$];

    bit prev_lk = 1'b0;
    bit prev_fl = 1'b0;

    frl_rx_tap_train_ctrl #(
        .PATTERN    (PAT),
        .WINDOW     (WIN),
        .SETTLE_CYC (SET),
        .MIN_EYE    (MINE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .retrain   (retrain),
        .count     (count),
        .ud        (ud),
        .tap_pos   (tap_pos),
        .locked    (locked),
        .fail      (fail),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Downstream up/down counter model plus pulse tallies since the last clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tap <= '0;
            inc_n <= 0;
            dec_n <= 0;
        end else begin
            case ({count, ud})
                2'b00: begin m_tap <= '0; inc_n <= 0; dec_n <= 0; end
                2'b11: begin m_tap <= m_tap + 7'd1; inc_n <= inc_n + 1; end
                2'b10: begin m_tap <= m_tap - 7'd1; dec_n <= dec_n + 1; end
                default: ;
            endcase
        end
    end

    always @(posedge clk) tog <= ~tog;

    // Channel: the training word arrives intact only at taps inside the open ranges.
    always_comb begin
        din_valid = half ? tog : 1'b1;
        if (!corrupt && ((int'(m_tap) >= lo1 && int'(m_tap) <= hi1) ||
                         (int'(m_tap) >= lo2 && int'(m_tap) <= hi2)))
            din = PAT;
        else
            din = ~PAT;
    end

    // Monitor: a rising locked or fail ends a sweep; compare against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ((locked && !prev_lk) || (fail && !prev_fl))) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("inc_pulses", inc_n, e.inc);
                chk("dec_pulses", dec_n, e.dec);
                chk("tap_pos", tap_pos, e.tap);
                chk("counter_model", m_tap, e.tap);
                chk("locked", locked, e.lk);
                chk("fail", fail, e.fl);
            end
        end
        prev_lk <= locked;
        prev_fl <= fail;
    end

    task automatic push_exp(input int i, input int d, input int t, input bit l, input bit f);
        exp_t e;
        e.inc = i; e.dec = d; e.tap = t; e.lk = l; e.fl = f;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!(locked || fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk({tag, "_timeout"}, 1, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic pulse_retrain(input string tag);
        @(negedge clk);
        retrain = 1'b1;
        @(negedge clk);
        retrain = 1'b0;
        chk({tag, "_cmd"}, {count, ud}, 0);
        chk({tag, "_tap"}, tap_pos, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err"}, err_cnt, 0);
    endtask

    initial begin
        int bad;
        int n;
        rst_n   = 1'b0;
        retrain = 1'b0;
        lo1 = 40; hi1 = 59; lo2 = -1; hi2 = -2;

        repeat (3) @(negedge clk);
        chk("rst_cmd", {count, ud}, 0);
        chk("rst_tap", tap_pos, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err", err_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset asynchronously while measuring at tap 3.
        n = 0;
        while (tap_pos != 7'd3 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("reach_tap3_timeout", 1, 0);
        repeat (SET + 3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cmd", {count, ud}, 0);
        chk("async_rst_tap", tap_pos, 0);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_err", err_cnt, 0);
        push_exp(60, 11, 49, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release_clear", {count, ud}, 0);
        bad = 0;
        repeat (SET) begin
            @(negedge clk);
            if ({count, ud} != 2'b01) bad++;
        end
        chk("settle_hold", bad, 0);
        wait_done(8000, "eye40_59");

        // No eye anywhere.
        lo1 = -1; hi1 = -2;
        push_exp(127, 0, 127, 1'b0, 1'b1);
        pulse_retrain("rt_noeye");
        wait_done(8000, "noeye");
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({count, ud} != 2'b01 || tap_pos != 7'd127 || !fail) bad++;
        end
        chk("fail_hold", bad, 0);

        // Narrow eye rejected, wide eye centred.
        lo1 = 10; hi1 = 12; lo2 = 70; hi2 = 90;
        push_exp(91, 11, 80, 1'b1, 1'b0);
        pulse_retrain("rt_two_eyes");
        wait_done(8000, "two_eyes");

        // Eye reaching the top tap.
        lo1 = 100; hi1 = 127; lo2 = -1; hi2 = -2;
        push_exp(127, 14, 113, 1'b1, 1'b0);
        pulse_retrain("rt_top_eye");
        wait_done(8000, "top_eye");
        chk("err_clean", err_cnt, 0);
        corrupt = 1'b1;
        repeat (3) @(negedge clk);
        corrupt = 1'b0;
        @(negedge clk);
        chk("err_three", err_cnt, 3);
        corrupt = 1'b1;
        repeat (65534) @(negedge clk);
        corrupt = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_saturated", err_cnt, 65535);
        chk("lock_kept", locked, 1);

        // Half-rate valid, retrain while centring.
        half = 1'b1;
        lo1 = 40; hi1 = 59;
        pulse_retrain("rt_half");
        n = 0;
        while (!(count && !ud) && n < 10000) begin @(negedge clk); n++; end
        if (n >= 10000) chk("center_timeout", 1, 0);
        chk("center_seen_locked", locked, 0);
        pulse_retrain("rt_mid_center");
        push_exp(60, 11, 49, 1'b1, 1'b0);
        wait_done(10000, "half_valid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
